// File: rtl/nanov_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nanov_uart_pkg
// Description : Shared definitions for the nanoV UART blocks. Holds the
//               receive FSM state encoding, the default clock and bit rate,
//               and the MMIO addresses the top level decodes for the RX
//               data and status registers.
// Revision    : 1.0 - initial release
// ============================================================================
package nanov_uart_pkg;

    localparam int unsigned c_DEFAULT_CLK_HZ   = 24_000_000;
    localparam int unsigned c_DEFAULT_BIT_RATE = 115_200;

    localparam logic [31:0] c_RX_DATA_ADDR     = 32'h1000_0104;
    localparam logic [31:0] c_RX_STATUS_ADDR   = 32'h1000_0108;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit, truncated.
    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : CPU-side read bus of the UART receiver.
//               master : CPU read path (drives rd_en, err_clear)
//               slave  : receiver (drives rd_data, rd_valid, rx_count,
//                        overrun, frame_err)
//               Parameter FIFO_DEPTH sizes rx_count ($clog2(FIFO_DEPTH)+1).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               rd_en;
    logic               err_clear;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic [c_CNT_W-1:0] rx_count;
    logic               overrun;
    logic               frame_err;

    modport master (
        output rd_en, err_clear,
        input  rd_data, rd_valid, rx_count, overrun, frame_err
    );

    modport slave (
        input  rd_en, err_clear,
        output rd_data, rd_valid, rx_count, overrun, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO with a registered head byte.
//               Ports: clk, rst_n (sync, active-low), push/push_data,
//               pop, head_data (8'h00 when empty), full, empty, count.
//               A push while full is accepted only together with a pop;
//               a pop while empty is ignored. DEPTH = 1 gives a single
//               holding register; otherwise DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  push,
    input  wire logic [7:0]            push_data,
    input  wire logic                  pop,
    output logic      [7:0]            head_data,
    output logic                       full,
    output logic                       empty,
    output logic      [$clog2(DEPTH):0] count
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [c_CW-1:0] r_count;
    logic [7:0]      r_head_data;
    logic [7:0]      w_head_next;
    logic [7:0]      w_next_entry;   // entry behind the current head
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == c_CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || pop);

    // Head byte is kept in its own register so rd_data never depends
    // combinationally on the pop strobe.
    always_comb begin
        w_head_next = r_head_data;
        if (w_do_pop) begin
            if (r_count == c_CW'(1)) begin
                // Last entry leaves; a same-cycle push becomes the new head.
                w_head_next = w_do_push ? push_data : 8'h00;
            end else begin
                w_head_next = w_next_entry;
            end
        end else if (w_do_push && empty) begin
            w_head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_head_data <= 8'h00;
        end else begin
            r_count     <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
            r_head_data <= w_head_next;
        end
    end

    generate
        if (DEPTH > 1) begin : g_ring
            localparam int c_AW = $clog2(DEPTH);

            logic [7:0]      r_mem [DEPTH];
            logic [c_AW-1:0] r_rd_ptr;
            logic [c_AW-1:0] r_wr_ptr;
            logic [c_AW-1:0] w_rd_ptr_inc;

            // Power-of-two depth: pointers wrap by plain overflow.
            assign w_rd_ptr_inc = r_rd_ptr + c_AW'(1);
            assign w_next_entry = r_mem[w_rd_ptr_inc];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                end else begin
                    if (w_do_push) begin
                        r_mem[r_wr_ptr] <= push_data;
                        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
                    end
                    if (w_do_pop) begin
                        r_rd_ptr <= w_rd_ptr_inc;
                    end
                end
            end
        end else begin : g_single
            // The head register is the only storage.
            assign w_next_entry = 8'h00;
        end
    endgenerate

    assign head_data = r_head_data;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with byte buffer for the nanoV top level.
//               Ports: clk, rst_n (sync, active-low), uart_rxd (async serial
//               in, idles high), rd_bus (uart_rx_fifo_if.slave: rd_en,
//               rd_data, rd_valid, rx_count, overrun, frame_err, err_clear).
//               Build macro UART_RX_FIFO_EN: defined -> FIFO_DEPTH-entry
//               FIFO; undefined -> single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import nanov_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = c_DEFAULT_CLK_HZ,
    parameter int unsigned BIT_RATE   = c_DEFAULT_BIT_RATE,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     uart_rxd,
    uart_rx_fifo_if.slave rd_bus
);
    localparam int unsigned       c_CPB       = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int                c_TMR_W     = $clog2(c_CPB);
    localparam logic [c_TMR_W-1:0] c_HALF_LOAD = c_TMR_W'(c_CPB / 2 - 1);
    localparam logic [c_TMR_W-1:0] c_FULL_LOAD = c_TMR_W'(c_CPB - 1);
    localparam int                c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_FIFO_EN
    localparam int                c_STORE_DEPTH = FIFO_DEPTH;
`else
    localparam int                c_STORE_DEPTH = 1;
`endif
    localparam int                c_STORE_CW  = $clog2(c_STORE_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to the idle level)
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       w_rxd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], uart_rxd};
        end
    end

    assign w_rxd = r_sync[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t          r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_tick;
    logic               w_push;
    logic               w_stop_bad;

    assign w_tick     = (r_tmr == '0);
    // Push and framing error fire on the stop-sample edge itself so the
    // FSM can be back in IDLE for a following frame.
    assign w_push     = (r_state == RX_STOP) && w_tick && w_rxd;
    assign w_stop_bad = (r_state == RX_STOP) && w_tick && !w_rxd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_tmr     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    // BREAK guarantees the line was high before IDLE, so a
                    // low level here is a falling edge.
                    if (!w_rxd) begin
                        r_state <= RX_START;
                        r_tmr   <= c_HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (!w_rxd) begin
                            r_state   <= RX_DATA;
                            r_tmr     <= c_FULL_LOAD;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= RX_IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        r_tmr <= r_tmr - c_TMR_W'(1);
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rxd, r_shift[7:1]};   // LSB first
                        r_tmr     <= c_FULL_LOAD;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_tmr <= r_tmr - c_TMR_W'(1);
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_state <= w_rxd ? RX_IDLE : RX_BREAK;
                    end else begin
                        r_tmr <= r_tmr - c_TMR_W'(1);
                    end
                end
                RX_BREAK: begin
                    if (w_rxd) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte storage
    // ------------------------------------------------------------------
    logic [7:0]            w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [c_STORE_CW-1:0] w_store_count;
    logic                  w_drop;

    byte_fifo #(
        .DEPTH (c_STORE_DEPTH)
    ) u_byte_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (rd_bus.rd_en),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_store_count)
    );

    // A full store still accepts a byte when the head leaves in the same
    // cycle, so only an unmatched push is a drop.
    assign w_drop = w_push && w_full && !rd_bus.rd_en;

    // ------------------------------------------------------------------
    // Sticky error flags (a set event beats a clear)
    // ------------------------------------------------------------------
    logic r_overrun;
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (rd_bus.err_clear) begin
                r_overrun <= 1'b0;
            end
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (rd_bus.err_clear) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign rd_bus.rd_data   = w_head;
    assign rd_bus.rd_valid  = !w_empty;
    assign rd_bus.rx_count  = c_CNT_W'(w_store_count);
    assign rd_bus.overrun   = r_overrun;
    assign rd_bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a small byte FIFO for the nanoV Tiny Tapeout top level. It deserialises 8N1 frames from the `uart_rxd` pad (bidirectional pin 5, input-only) and buffers the bytes. The CPU's memory-mapped read path consumes them through a pop strobe. It is the receive-side counterpart of the existing `uart_tx` and runs at the same 24 MHz / 115200 baud.

## Interface
Parameters:
- `CLK_HZ`, default 24_000_000: system clock frequency in Hz.
- `BIT_RATE`, default 115_200: baud rate. Bit period is `CPB = CLK_HZ / BIT_RATE`, integer division, 208 at defaults.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `uart_rxd`  in  1  asynchronous serial input; idles high.
- `rd_en`  in  1  pop strobe; one byte is removed per cycle while `rd_valid` is high.
- `rd_data`  out  8  FIFO head byte; 8'h00 when empty.
- `rd_valid`  out  1  FIFO not empty.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky flag: a stop bit was sampled low.
- `err_clear`  in  1  clears `overrun` and `frame_err`.

## Operation
- Input synchroniser: a 2-flop chain. Both flops reset to 1.
- Receive FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: a synchronised falling edge moves to START and loads the bit counter with `CPB/2 - 1`.
  - START: when the counter expires, the line is sampled.
    - Low: go to DATA with counter = `CPB-1` and bit index 0.
    - High: a glitch. Return to IDLE with no flag set.
  - DATA: sample one bit on each counter expiry and shift it in LSB-first. After bit 7, go to STOP.
  - STOP: sample on counter expiry.
    - High: push the byte and go to IDLE.
    - Low: set `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for the synchronised line to be high, then go to IDLE.
- FIFO behaviour:
  - Circular buffer with head and tail pointers plus a count.
  - Push while full: the byte is dropped, `overrun` is set, and the contents are unchanged.
  - Push and pop in the same cycle with the FIFO full: both take effect, the count is unchanged, and `overrun` stays clear.
  - Push and pop in the same cycle with the FIFO empty: the push takes effect and the pop is ignored.
  - Pop while empty: ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Flags:
  - `overrun` and `frame_err` hold until `err_clear` or reset.
  - If a set event and `err_clear` occur in the same cycle, set wins.
- Reset:
  - Every output is 0: `rd_data`=0, `rd_valid`=0, `rx_count`=0, and both flags 0.
  - The FSM returns to IDLE, the FIFO is emptied, and the shift register is cleared.
  - A frame in progress when reset asserts is abandoned. It is neither pushed nor flagged.

## Timing
- Let t0 be the first clock edge where `uart_rxd` is sampled low at the pin.
  - The synchronised falling edge is seen at t0+2.
  - The start-bit midpoint is sampled at t0+2+`CPB/2`.
  - Data bit n is sampled `CPB*(n+1)` cycles after the start-bit midpoint.
  - The stop bit is sampled `9*CPB` cycles after the start-bit midpoint.
- The push happens on the stop-sample edge. `rd_valid`, `rd_data` and `rx_count` update on the next cycle.
- A pop on edge k updates `rd_data`, `rd_valid` and `rx_count` after edge k.
- The FSM is in IDLE immediately after the stop sample, so frames can be back-to-back with a 1-bit stop.
- `rd_data` is registered-output head data with no combinational path from `rd_en`.

## Configuration
- `UART_RX_FIFO_EN`
  - Defined: FIFO of `FIFO_DEPTH` entries, as described above.
  - Undefined: a single holding register. `FIFO_DEPTH` is ignored, `rx_count` is 0 or 1, and a second byte arriving before a pop sets `overrun` and is dropped. The simultaneous pop-and-push rule still applies.

## Structure
- Shared package `nanov_uart_pkg`:
  - FSM state enum `rx_state_t`.
  - Default `CLK_HZ` and `BIT_RATE`.
  - MMIO constants: RX data address 32'h10000104 and status address 32'h10000108, used by the top level.
- One sub-module, `byte_fifo`: a parameterised synchronous FIFO with push, pop, full, empty and count. The receiver FSM lives in `uart_rx_fifo`.

## Test plan
All scenarios use defaults with `CPB`=208 and `UART_RX_FIFO_EN` defined unless stated.
- Single frame 8'hA5: `rd_valid` rises one cycle after the stop sample, `rd_data`=8'hA5, `rx_count`=1. One pop gives `rd_valid`=0 and `rd_data`=8'h00.
- Low glitch of 50 cycles on an idle line: no byte, no flags, FSM returns to IDLE.
- Frame 8'h3C with the stop bit held low: `frame_err`=1 and `rx_count`=0. Line high again, then frame 8'h11: received correctly. `err_clear` then clears `frame_err`.
- Five back-to-back frames 8'h01..8'h05 with no pops: `rx_count`=4, `overrun`=1, and pops return 01, 02, 03, 04.
- FIFO full, with `rd_en` pulsed on the stop-sample edge of frame 8'h77: `overrun`=0, `rx_count` stays 4, and the last entry is 8'h77.
- `rst_n` low during bit 4 of a frame: all outputs 0. After release, the next full frame 8'h5A is received correctly.
- `UART_RX_FIFO_EN` undefined, two frames without a pop: only the first byte is held and `overrun`=1.
